barrel_unshifter16: RTL and testbench

- Sequential inverse of barrel_shifter16: takes a 16-bit word already rotated by barrel_shifter16 and restores the original.
- Uses the same amount (s3..s0) and direction (shift_sel) encoding that was applied on the forward path, and rotates the opposite way, one bit position per clock.
- Sits on the receive side of the shift datapath, after barrel_shifter16.
- Uses a start/busy/done handshake, so the forward combinational shifter and this iterative unit can be chained and checked back-to-back.

---
 rtl/barrel_unshifter16.sv | 80 ++++++++
 tb/tb_barrel_unshifter16.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_unshifter16.sv
// Iterative inverse of barrel_shifter16: rotates a captured word back one bit per
// clock in the opposite direction, with a start/busy/done handshake.
module barrel_unshifter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] i,
    input  logic        s0,
    input  logic        s1,
    input  logic        s2,
    input  logic        s3,
    input  logic        shift_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] o
);

    localparam int DATA_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] d;
    logic [3:0]        cnt;
    logic              dir;
    logic [3:0]        amt;

    // dir=1 undoes a forward left rotation, so it steps right.
    function automatic logic [DATA_W-1:0] rot1(input logic [DATA_W-1:0] v, input logic right);
        return right ? {v[0], v[DATA_W-1:1]} : {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    assign amt  = {s3, s2, s1, s0};
    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            d     <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d   <= i;
                        cnt <= amt;
                        dir <= shift_sel;
                        if (amt == 4'd0) begin
                            state <= DONE;
                            o     <= i;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    d   <= rot1(d, dir);
                    cnt <= cnt - 4'd1;
                    // Last rotation lands directly in o so done and data appear together.
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        o     <= rot1(d, dir);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_unshifter16.sv
// Self-checking bench for barrel_unshifter16: directed cases, reset behaviour,
// ignored starts, back-to-back operation and randomized round trips.
module tb_barrel_unshifter16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] i;
    logic [3:0]  amt;
    logic        shift_sel;
    logic        busy;
    logic        done;
    logic [15:0] o;

    int passes = 0;
    int total  = 0;

    barrel_unshifter16 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i         (i),
        .s0        (amt[0]),
        .s1        (amt[1]),
        .s2        (amt[2]),
        .s3        (amt[3]),
        .shift_sel (shift_sel),
        .busy      (busy),
        .done      (done),
        .o         (o)
    );

    always #5 clk = ~clk;

    // Reference: plain rotations on a doubled word.
    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        logic [31:0] t;
        t = {x, x} << n;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        logic [31:0] t;
        t = {x, x} >> n;
        return t[15:0];
    endfunction

    // Forward barrel_shifter16: shift_sel=1 rotates left, 0 rotates right.
    function automatic logic [15:0] fwd(input logic [15:0] x, input int n, input logic sel);
        return sel ? rotl(x, n) : rotr(x, n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; with disturb set, inputs are scrambled and start is
    // pulsed every cycle while the unit is busy.
    task automatic run_op(input string tag, input logic [15:0] din, input int n,
                          input logic sel, input logic [15:0] exp, input bit disturb);
        int  cyc;
        bit  got;
        bit  busy_drop;
        @(negedge clk);
        i = din; amt = 4'(n); shift_sel = sel; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; got = 0; busy_drop = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_drop = 1;
            if (done) begin
                got = 1;
                break;
            end
            if (disturb) begin
                i = 16'($urandom); amt = 4'($urandom); shift_sel = 1'($urandom); start = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
        check({tag, "_o"}, 32'(o), 32'(exp));
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_o_hold"}, 32'(o), 32'(exp));
    endtask

    initial begin
        int dcount;
        int first_done;
        int second_done;
        logic [15:0] orig;
        int          rn;
        logic        rs;

        rst = 1'b1; start = 1'b0; i = '0; amt = '0; shift_sel = 1'b0;
        #1;
        check("reset_o", 32'(o), 32'h0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("left_inv", 16'h186A, 6, 1'b1, 16'hA861, 1'b0);
        run_op("right_inv", 16'h8001, 1, 1'b0, 16'h0003, 1'b0);
        run_op("n0", 16'h1234, 0, 1'b1, 16'h1234, 1'b0);
        run_op("n15", 16'h0001, 15, 1'b1, 16'h0002, 1'b0);
        run_op("disturb", 16'h186A, 6, 1'b1, 16'hA861, 1'b1);

        // Asynchronous reset mid-cycle with a nonzero o
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_o", 32'(o), 32'h0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during SHIFT aborts without a done pulse
        @(negedge clk);
        i = 16'h186A; amt = 4'd6; shift_sel = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midop_rst_o", 32'(o), 32'h0);
        check("midop_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midop_no_done", 32'(dcount), 32'd0);
        check("midop_o_zero", 32'(o), 32'h0);
        run_op("after_rst", 16'h186A, 6, 1'b1, 16'hA861, 1'b0);

        // Start held high: operations repeat every N+2 edges
        @(negedge clk);
        orig = 16'($urandom);
        i = fwd(orig, 2, 1'b0); amt = 4'd2; shift_sel = 1'b0; start = 1'b1;
        first_done = -1; second_done = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        check("b2b_first_seen", 32'(first_done >= 0), 32'd1);
        check("b2b_period", 32'(second_done - first_done), 32'd4);
        check("b2b_o", 32'(o), 32'(orig));
        repeat (8) @(negedge clk);

        // Randomized round trips through the forward shifter model
        for (int r = 0; r < 24; r++) begin
            orig = 16'($urandom);
            rn   = int'($urandom_range(0, 15));
            rs   = 1'($urandom);
            run_op($sformatf("rt%0d", r), fwd(orig, rn, rs), rn, rs, orig, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
